// File: rtl/irq_request_latch.sv
// Request latch feeding the 4-to-2 priority encoder: edge-detected sticky pending bits, masking, ack clear, overflow flags.
// Define IRQ_REQ_SYNC_EN to add a 2-flop input synchroniser per request line (asynchronous sources).
module irq_request_latch #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             ack,
  input  logic [1:0]       ack_idx,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] pend_out,
  output logic             irq,
  output logic [WIDTH-1:0] overflow,
  output logic             ack_err
);

  logic [WIDTH-1:0] req_s;
  logic [WIDTH-1:0] req_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] pending;

`ifdef IRQ_REQ_SYNC_EN
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Reset to all-ones so a level already high through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= req_in;
      sync2 <= sync1;
    end
  end

  assign req_s = sync2;
`else
  assign req_s = req_in;
`endif

  assign rise = req_s & ~req_q;

  always_comb begin
    hit = '0;
    if (ack) hit[ack_idx] = 1'b1;
  end

  // A rise on a line being acked in the same cycle replaces the serviced event, so no overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= '1;
      pending  <= '0;
      overflow <= '0;
      ack_err  <= 1'b0;
    end else begin
      req_q    <= req_s;
      pending  <= (pending & ~hit) | rise;
      overflow <= (rise & pending & ~hit) | (overflow & {WIDTH{~ovf_clr}});
      ack_err  <= ack & ~pending[ack_idx];
    end
  end

  assign pend_out = pending & ~mask;
  assign irq      = |pend_out;

endmodule

// File: doc/irq_request_latch.md
# irq_request_latch

Upstream stage of the 4-to-2 priority encoder. Converts four request lines into sticky pending bits on their rising edges, applies a per-line mask, and presents the masked pending vector to the encoder's `in[3:0]`. The encoder's `out[1:0]` is returned as `ack_idx` to clear the serviced request. Per-line overflow flags record requests lost while a line is already pending.

## Interface
Parameters:
- `WIDTH`, 4, number of request lines. Fixed at 4 to match the encoder. Other values are unsupported.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req_in`  input  4  request levels; an event is a 0→1 transition.
- `mask`  input  4  1 = line masked from `pend_out`; its pending bit is still held.
- `ack`  input  1  single-cycle acknowledge strobe.
- `ack_idx`  input  2  index being acknowledged; sampled only when `ack`=1.
- `ovf_clr`  input  1  clears all overflow flags.
- `pend_out`  output  4  `pending & ~mask`, combinational from registers; drives the encoder's `in`.
- `irq`  output  1  OR-reduction of `pend_out`; equivalent to the encoder's `valid`.
- `overflow`  output  4  sticky per-line lost-event flags, registered.
- `ack_err`  output  1  registered one-cycle pulse; the previous cycle acknowledged a non-pending line.

## Operation
- Internal registers:
  - `req_q[3:0]`: previous sampled request.
  - `pending[3:0]`
  - `overflow[3:0]`
  - `ack_err`
- Edge detect: `rise[i] = req_s[i] & ~req_q[i]`. `req_s` is `req_in`, or its synchronised copy (see Configuration). `req_q <= req_s` every cycle.
- Per line i, each edge, in priority order:
  - `rise[i]` → `pending[i] <= 1`. If `pending[i]` was already 1 and not being acked this cycle, also `overflow[i] <= 1`.
  - Else if `ack & ack_idx==i` → `pending[i] <= 0`.
  - Else hold.
- Simultaneous rise and ack on the same line:
  - Set wins; `pending` stays 1.
  - The old event is serviced and the new event is retained, so no overflow.
- Ack of a line with `pending`=0 (including masked-zero or out-of-range states):
  - No state change.
  - `ack_err <= 1` for exactly one cycle.
- Ack of a masked but pending line clears it normally. Masking never clears `pending`.
- `ovf_clr`:
  - Clears all `overflow` bits.
  - A same-cycle overflow set wins over `ovf_clr` for that line.
- Reset (`rst_n`=0 at an edge):
  - `pending` = 0, `overflow` = 0, `ack_err` = 0, `req_q` = 4'b1111.
  - Synchroniser flops, if present, = 4'b1111.
  - A level held high through reset therefore generates no event; the line must drop low and rise again.
  - Reset mid-operation discards all pending and overflow state at that edge.

## Timing
- Latency, `req_in` rise to `pend_out`/`irq`:
  - 1 cycle without synchroniser. `req_in` high before edge k gives `pend_out` high after edge k.
  - 3 cycles with synchroniser.
- `ack` at edge k: `pend_out` bit low after edge k. The encoder output updates combinationally in the same cycle.
- `mask` changes affect `pend_out`/`irq` combinationally with zero cycles.
- `ack_err` is asserted in the cycle after the offending ack edge.
- Back-to-back acks on consecutive cycles are legal; each is evaluated independently.
- All outputs after reset: `pend_out`=0, `irq`=0, `overflow`=0, `ack_err`=0.

## Configuration
- Macro: `IRQ_REQ_SYNC_EN`.
- Defined:
  - `req_in` passes through a 2-flop synchroniser per line before edge detection.
  - Request-to-`pend_out` latency is 3 cycles.
  - The block accepts asynchronous request sources.
- Undefined:
  - No synchroniser; `req_in` must be synchronous to `clk`.
  - Latency is 1 cycle.
- All other behaviour is identical in both builds. The bench runs both builds, with latency checks scaled accordingly.

## Test plan
- Reset with `req_in`=4'b1111 held, then release:
  - `pend_out`=0, `irq`=0 indefinitely.
  - Drop `req_in[2]` then raise it: `pend_out`=4'b0100, `irq`=1 after the required latency.
- Rise on lines 1 and 3 in the same cycle, `mask`=0:
  - `pend_out`=4'b1010.
  - Ack idx 3: `pend_out`=4'b0010.
  - Ack idx 1: `pend_out`=0, `irq`=0.
- Line 0 pending, pulse `req_in[0]` again without ack: `overflow`=4'b0001.
  - Then `ovf_clr`: `overflow`=0.
- Line 2 pending; ack idx 2 in the same cycle as a new `req_in[2]` rise:
  - `pending[2]` stays 1, `overflow[2]`=0.
- `mask`=4'b1000 with line 3 pending:
  - `pend_out`=0, `irq`=0.
  - Clear `mask`: `pend_out`=4'b1000 immediately.
  - Ack idx 0 while line 0 is not pending: `ack_err`=1 for one cycle, `pend_out` unchanged.
- Assert `rst_n`=0 while lines 0 and 3 are pending and overflowed:
  - After the edge, `pend_out`, `overflow` and `ack_err` are all 0.
